// File: rtl/ysyx_041461_axi_xbar_if.sv
// AXI4 signal bundle shared by the crossbar's upstream port and its two
// downstream ports. "master" drives requests, "slave" drives responses.
interface ysyx_041461_axi_xbar_if;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rresp, rdata, rlast, output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rresp, rdata, rlast, input rready
  );
endinterface

// File: rtl/ysyx_041461_axi_xbar.sv
// One-master / two-slave AXI4 router (CLINT, memory) with an internal DECERR
// responder for unmapped addresses. One transaction in flight at a time.
module ysyx_041461_axi_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_041461_axi_xbar_if.slave         in_s,
  ysyx_041461_axi_xbar_if.master        clint_m,
  ysyx_041461_axi_xbar_if.master        mem_m
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_W_RESP, S_R_ADDR, S_R_DATA
  } state_e;

  typedef enum logic [1:0] { T_CLINT, T_MEM, T_ERR } tgt_e;

  state_e      state_q, state_d;
  tgt_e        tgt_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [7:0]  cnt_q;

  function automatic tgt_e decode(input logic [31:0] a);
    if (a[31:16] == CLINT_BASE[31:16]) return T_CLINT;
    else if (a[31] == MEM_BASE[31])    return T_MEM;
    else                               return T_ERR;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Request capture; ERR beat counter saturates at len so it never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q <= T_CLINT; id_q <= '0; addr_q <= '0; len_q <= '0;
      size_q <= '0; burst_q <= '0; cnt_q <= '0;
    end else if (state_q == S_IDLE && in_s.awvalid) begin
      tgt_q <= decode(in_s.awaddr); id_q <= in_s.awid; addr_q <= in_s.awaddr;
      len_q <= in_s.awlen; size_q <= in_s.awsize; burst_q <= in_s.awburst;
      cnt_q <= '0;
    end else if (state_q == S_IDLE && in_s.arvalid) begin
      tgt_q <= decode(in_s.araddr); id_q <= in_s.arid; addr_q <= in_s.araddr;
      len_q <= in_s.arlen; size_q <= in_s.arsize; burst_q <= in_s.arburst;
      cnt_q <= '0;
    end else if (state_q == S_R_DATA && tgt_q == T_ERR && in_s.rready &&
                 cnt_q != len_q) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Next-state: transitions follow the handshakes produced by the output block
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (in_s.awvalid)
          state_d = (decode(in_s.awaddr) == T_ERR) ? S_W_DATA : S_W_ADDR;
        else if (in_s.arvalid)
          state_d = (decode(in_s.araddr) == T_ERR) ? S_R_DATA : S_R_ADDR;
      S_W_ADDR:
        if ((tgt_q == T_CLINT && clint_m.awready) || (tgt_q == T_MEM && mem_m.awready))
          state_d = S_W_DATA;
      S_W_DATA:
        if (in_s.wvalid && in_s.wready && in_s.wlast) state_d = S_W_RESP;
      S_W_RESP:
        if (in_s.bvalid && in_s.bready) state_d = S_IDLE;
      S_R_ADDR:
        if ((tgt_q == T_CLINT && clint_m.arready) || (tgt_q == T_MEM && mem_m.arready))
          state_d = S_R_DATA;
      S_R_DATA:
        if (in_s.rvalid && in_s.rready && in_s.rlast) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: payloads broadcast to both slaves, only the selected valid/ready moves
  always_comb begin
    in_s.awready = 1'b0; in_s.arready = 1'b0; in_s.wready = 1'b0;
    in_s.bvalid = 1'b0; in_s.bid = '0; in_s.bresp = '0;
    in_s.rvalid = 1'b0; in_s.rid = '0; in_s.rresp = '0; in_s.rdata = '0; in_s.rlast = 1'b0;

    clint_m.awvalid = 1'b0; clint_m.awid = id_q; clint_m.awaddr = addr_q;
    clint_m.awlen = len_q; clint_m.awsize = size_q; clint_m.awburst = burst_q;
    clint_m.wvalid = 1'b0; clint_m.wdata = in_s.wdata; clint_m.wstrb = in_s.wstrb;
    clint_m.wlast = in_s.wlast; clint_m.bready = 1'b0;
    clint_m.arvalid = 1'b0; clint_m.arid = id_q; clint_m.araddr = addr_q;
    clint_m.arlen = len_q; clint_m.arsize = size_q; clint_m.arburst = burst_q;
    clint_m.rready = 1'b0;

    mem_m.awvalid = 1'b0; mem_m.awid = id_q; mem_m.awaddr = addr_q;
    mem_m.awlen = len_q; mem_m.awsize = size_q; mem_m.awburst = burst_q;
    mem_m.wvalid = 1'b0; mem_m.wdata = in_s.wdata; mem_m.wstrb = in_s.wstrb;
    mem_m.wlast = in_s.wlast; mem_m.bready = 1'b0;
    mem_m.arvalid = 1'b0; mem_m.arid = id_q; mem_m.araddr = addr_q;
    mem_m.arlen = len_q; mem_m.arsize = size_q; mem_m.arburst = burst_q;
    mem_m.rready = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_s.awready = 1'b1;
        in_s.arready = ~in_s.awvalid;
      end
      S_W_ADDR: begin
        clint_m.awvalid = (tgt_q == T_CLINT);
        mem_m.awvalid   = (tgt_q == T_MEM);
      end
      S_W_DATA:
        case (tgt_q)
          T_CLINT: begin clint_m.wvalid = in_s.wvalid; in_s.wready = clint_m.wready; end
          T_MEM:   begin mem_m.wvalid = in_s.wvalid;   in_s.wready = mem_m.wready;   end
          default: in_s.wready = 1'b1;
        endcase
      S_W_RESP:
        case (tgt_q)
          T_CLINT: begin
            in_s.bvalid = clint_m.bvalid; in_s.bid = clint_m.bid;
            in_s.bresp = clint_m.bresp; clint_m.bready = in_s.bready;
          end
          T_MEM: begin
            in_s.bvalid = mem_m.bvalid; in_s.bid = mem_m.bid;
            in_s.bresp = mem_m.bresp; mem_m.bready = in_s.bready;
          end
          default: begin
            in_s.bvalid = 1'b1; in_s.bid = id_q; in_s.bresp = 2'b11;
          end
        endcase
      S_R_ADDR: begin
        clint_m.arvalid = (tgt_q == T_CLINT);
        mem_m.arvalid   = (tgt_q == T_MEM);
      end
      S_R_DATA:
        case (tgt_q)
          T_CLINT: begin
            in_s.rvalid = clint_m.rvalid; in_s.rid = clint_m.rid; in_s.rresp = clint_m.rresp;
            in_s.rdata = clint_m.rdata; in_s.rlast = clint_m.rlast;
            clint_m.rready = in_s.rready;
          end
          T_MEM: begin
            in_s.rvalid = mem_m.rvalid; in_s.rid = mem_m.rid; in_s.rresp = mem_m.rresp;
            in_s.rdata = mem_m.rdata; in_s.rlast = mem_m.rlast;
            mem_m.rready = in_s.rready;
          end
          default: begin
            in_s.rvalid = 1'b1; in_s.rid = id_q; in_s.rresp = 2'b11;
            in_s.rdata = '0; in_s.rlast = (cnt_q == len_q);
          end
        endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_041461_axi_xbar.sv
// Directed bench for the CLINT/MEM/DECERR router. Inputs change just after
// the falling edge; outputs are checked 1ns later, well clear of the rising edge.
module tb_ysyx_041461_axi_xbar;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   mem_act = 0;
  int   snap;

  always #5 clk = ~clk;

  ysyx_041461_axi_xbar_if in_if ();
  ysyx_041461_axi_xbar_if clint_if ();
  ysyx_041461_axi_xbar_if mem_if ();

  ysyx_041461_axi_xbar dut (
    .clk     (clk),
    .rst     (rst),
    .in_s    (in_if),
    .clint_m (clint_if),
    .mem_m   (mem_if)
  );

  // Count cycles where the memory port shows any activity
  always @(posedge clk)
    if (mem_if.awvalid || mem_if.wvalid || mem_if.arvalid || mem_if.bready || mem_if.rready)
      mem_act <= mem_act + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Master side idle
    in_if.awvalid = 0; in_if.awid = 0; in_if.awaddr = 0; in_if.awlen = 0;
    in_if.awsize = 3'd3; in_if.awburst = 2'd1;
    in_if.wvalid = 0; in_if.wdata = 0; in_if.wstrb = 0; in_if.wlast = 0; in_if.bready = 0;
    in_if.arvalid = 0; in_if.arid = 0; in_if.araddr = 0; in_if.arlen = 0;
    in_if.arsize = 3'd3; in_if.arburst = 2'd1; in_if.rready = 0;
    // Slave response sides idle
    clint_if.awready = 0; clint_if.wready = 0; clint_if.bvalid = 0; clint_if.bid = 0;
    clint_if.bresp = 0; clint_if.arready = 0; clint_if.rvalid = 0; clint_if.rid = 0;
    clint_if.rresp = 0; clint_if.rdata = 0; clint_if.rlast = 0;
    mem_if.awready = 0; mem_if.wready = 0; mem_if.bvalid = 0; mem_if.bid = 0;
    mem_if.bresp = 0; mem_if.arready = 0; mem_if.rvalid = 0; mem_if.rid = 0;
    mem_if.rresp = 0; mem_if.rdata = 0; mem_if.rlast = 0;

    // ---- reset state
    step(); settle();
    chk("rst_awready", in_if.awready, 1);
    chk("rst_arready", in_if.arready, 1);
    chk("rst_wready", in_if.wready, 0);
    chk("rst_bvalid", in_if.bvalid, 0);
    chk("rst_rvalid", in_if.rvalid, 0);
    chk("rst_clint_awvalid", clint_if.awvalid, 0);
    chk("rst_mem_arvalid", mem_if.arvalid, 0);
    in_if.awvalid = 1; settle();
    chk("rst_arready_awv", in_if.arready, 0);
    in_if.awvalid = 0;
    step(); rst = 1;

    // ---- CLINT write
    step(); snap = mem_act;
    in_if.awvalid = 1; in_if.awaddr = 32'h0200_4000; in_if.awid = 4'd3; in_if.awlen = 0;
    settle();
    chk("w1_awready", in_if.awready, 1);
    chk("w1_clint_awvalid_n", clint_if.awvalid, 0);
    step(); in_if.awvalid = 0; settle();
    chk("w1_clint_awvalid", clint_if.awvalid, 1);
    chk("w1_clint_awaddr", clint_if.awaddr, 64'h0200_4000);
    chk("w1_clint_awid", clint_if.awid, 3);
    chk("w1_in_awready", in_if.awready, 0);
    clint_if.awready = 1;
    step(); clint_if.awready = 0;
    in_if.wvalid = 1; in_if.wdata = 64'h64; in_if.wstrb = 8'hFF; in_if.wlast = 1;
    settle();
    chk("w1_clint_awvalid_off", clint_if.awvalid, 0);
    chk("w1_clint_wvalid", clint_if.wvalid, 1);
    chk("w1_clint_wdata", clint_if.wdata, 64'h64);
    chk("w1_clint_wstrb", clint_if.wstrb, 8'hFF);
    chk("w1_wready_stall", in_if.wready, 0);
    clint_if.wready = 1; settle();
    chk("w1_wready", in_if.wready, 1);
    step(); in_if.wvalid = 0; in_if.wlast = 0; clint_if.wready = 0;
    clint_if.bvalid = 1; clint_if.bid = 4'd3; clint_if.bresp = 2'b00; in_if.bready = 1;
    settle();
    chk("w1_bvalid", in_if.bvalid, 1);
    chk("w1_bid", in_if.bid, 3);
    chk("w1_bresp", in_if.bresp, 0);
    chk("w1_clint_bready", clint_if.bready, 1);
    step(); clint_if.bvalid = 0; in_if.bready = 0; settle();
    chk("w1_idle_awready", in_if.awready, 1);
    chk("w1_idle_bvalid", in_if.bvalid, 0);
    chk("w1_mem_quiet", mem_act, snap);

    // ---- CLINT read
    in_if.arvalid = 1; in_if.araddr = 32'h0200_BFF8; in_if.arid = 4'd5; in_if.arlen = 0;
    settle();
    chk("r2_arready", in_if.arready, 1);
    step(); in_if.arvalid = 0; settle();
    chk("r2_clint_arvalid", clint_if.arvalid, 1);
    chk("r2_clint_araddr", clint_if.araddr, 64'h0200_BFF8);
    chk("r2_clint_arid", clint_if.arid, 5);
    clint_if.arready = 1;
    step(); clint_if.arready = 0;
    clint_if.rvalid = 1; clint_if.rid = 4'd5; clint_if.rresp = 0;
    clint_if.rdata = 64'h1122_3344_5566_7788; clint_if.rlast = 1; in_if.rready = 1;
    settle();
    chk("r2_rvalid", in_if.rvalid, 1);
    chk("r2_rdata", in_if.rdata, 64'h1122_3344_5566_7788);
    chk("r2_rid", in_if.rid, 5);
    chk("r2_rlast", in_if.rlast, 1);
    chk("r2_clint_rready", clint_if.rready, 1);
    step(); clint_if.rvalid = 0; clint_if.rlast = 0; in_if.rready = 0; settle();
    chk("r2_idle_awready", in_if.awready, 1);
    chk("r2_idle_rvalid", in_if.rvalid, 0);

    // ---- MEM burst read, len=3, rready toggling 0/1
    in_if.arvalid = 1; in_if.araddr = 32'h8000_0000; in_if.arid = 4'd1; in_if.arlen = 8'd3;
    step(); in_if.arvalid = 0; settle();
    chk("r3_mem_arvalid", mem_if.arvalid, 1);
    chk("r3_clint_arvalid", clint_if.arvalid, 0);
    chk("r3_mem_arlen", mem_if.arlen, 3);
    mem_if.arready = 1;
    step(); mem_if.arready = 0;
    for (int k = 0; k < 4; k++) begin
      mem_if.rvalid = 1; mem_if.rid = 4'd1; mem_if.rresp = 0;
      mem_if.rdata = 64'hA0 + 64'(k); mem_if.rlast = (k == 3);
      in_if.rready = 0; settle();
      chk("r3_stall_rvalid", in_if.rvalid, 1);
      chk("r3_stall_rready", mem_if.rready, 0);
      step(); settle();
      chk("r3_held_rdata", in_if.rdata, 64'hA0 + 64'(k));
      in_if.rready = 1; settle();
      chk("r3_mem_rready", mem_if.rready, 1);
      chk("r3_rlast", in_if.rlast, (k == 3) ? 64'd1 : 64'd0);
      step();
    end
    mem_if.rvalid = 0; mem_if.rlast = 0; in_if.rready = 0; settle();
    chk("r3_idle_awready", in_if.awready, 1);

    // ---- simultaneous write and read to MEM: write wins
    in_if.awvalid = 1; in_if.awaddr = 32'h8000_0010; in_if.awid = 4'd4; in_if.awlen = 0;
    in_if.arvalid = 1; in_if.araddr = 32'h8000_0010; in_if.arid = 4'd9; in_if.arlen = 0;
    settle();
    chk("s4_awready", in_if.awready, 1);
    chk("s4_arready", in_if.arready, 0);
    step(); in_if.awvalid = 0; settle();
    chk("s4_mem_awvalid", mem_if.awvalid, 1);
    chk("s4_mem_arvalid", mem_if.arvalid, 0);
    chk("s4_arready_busy", in_if.arready, 0);
    mem_if.awready = 1;
    step(); mem_if.awready = 0;
    in_if.wvalid = 1; in_if.wlast = 1; in_if.wdata = 64'hDEAD; mem_if.wready = 1; settle();
    chk("s4_wready", in_if.wready, 1);
    chk("s4_mem_wdata", mem_if.wdata, 64'hDEAD);
    step(); in_if.wvalid = 0; in_if.wlast = 0; mem_if.wready = 0;
    mem_if.bvalid = 1; mem_if.bid = 4'd4; mem_if.bresp = 0; in_if.bready = 1; settle();
    chk("s4_bvalid", in_if.bvalid, 1);
    chk("s4_bid", in_if.bid, 4);
    chk("s4_arready_resp", in_if.arready, 0);
    step(); mem_if.bvalid = 0; in_if.bready = 0; settle();
    chk("s4_arready_idle", in_if.arready, 1);
    step(); in_if.arvalid = 0; settle();
    chk("s4_mem_arvalid_rd", mem_if.arvalid, 1);
    chk("s4_mem_arid", mem_if.arid, 9);
    mem_if.arready = 1;
    step(); mem_if.arready = 0;
    mem_if.rvalid = 1; mem_if.rid = 4'd9; mem_if.rdata = 64'h55AA; mem_if.rlast = 1;
    in_if.rready = 1; settle();
    chk("s4_rdata", in_if.rdata, 64'h55AA);
    chk("s4_rid", in_if.rid, 9);
    step(); mem_if.rvalid = 0; mem_if.rlast = 0; in_if.rready = 0; settle();
    chk("s4_idle", in_if.awready, 1);

    // ---- unmapped read, id=2, len=1 -> internal DECERR
    in_if.arvalid = 1; in_if.araddr = 32'h1000_0000; in_if.arid = 4'd2; in_if.arlen = 8'd1;
    step(); in_if.arvalid = 0; in_if.rready = 1; settle();
    chk("e5_rvalid", in_if.rvalid, 1);
    chk("e5_rdata", in_if.rdata, 0);
    chk("e5_rresp", in_if.rresp, 3);
    chk("e5_rid", in_if.rid, 2);
    chk("e5_rlast0", in_if.rlast, 0);
    chk("e5_no_slave_ar", {clint_if.arvalid, mem_if.arvalid}, 0);
    step(); settle();
    chk("e5_rvalid1", in_if.rvalid, 1);
    chk("e5_rlast1", in_if.rlast, 1);
    step(); in_if.rready = 0; settle();
    chk("e5_idle_rvalid", in_if.rvalid, 0);
    chk("e5_idle_awready", in_if.awready, 1);

    // ---- unmapped write, len=3 but wlast on first beat ends the burst
    in_if.awvalid = 1; in_if.awaddr = 32'h1000_0000; in_if.awid = 4'd6; in_if.awlen = 8'd3;
    step(); in_if.awvalid = 0; settle();
    chk("e5w_wready", in_if.wready, 1);
    chk("e5w_no_slave_aw", {clint_if.awvalid, mem_if.awvalid}, 0);
    in_if.wvalid = 1; in_if.wlast = 1;
    step(); in_if.wvalid = 0; in_if.wlast = 0; in_if.bready = 1; settle();
    chk("e5w_bvalid", in_if.bvalid, 1);
    chk("e5w_bresp", in_if.bresp, 3);
    chk("e5w_bid", in_if.bid, 6);
    step(); in_if.bready = 0; settle();
    chk("e5w_idle", in_if.awready, 1);

    // ---- unmapped read, len=255: rlast only on the 256th beat
    in_if.arvalid = 1; in_if.araddr = 32'h0000_1000; in_if.arid = 4'd7; in_if.arlen = 8'd255;
    step(); in_if.arvalid = 0; in_if.rready = 1;
    for (int k = 0; k < 256; k++) begin
      settle();
      chk("e255_rlast", in_if.rlast, (k == 255) ? 64'd1 : 64'd0);
      step();
    end
    in_if.rready = 0; settle();
    chk("e255_idle_rvalid", in_if.rvalid, 0);
    chk("e255_idle_awready", in_if.awready, 1);

    // ---- reset during MEM write data phase
    in_if.awvalid = 1; in_if.awaddr = 32'h8000_0100; in_if.awid = 4'd7; in_if.awlen = 8'd1;
    step(); in_if.awvalid = 0; mem_if.awready = 1;
    step(); mem_if.awready = 0;
    in_if.wvalid = 1; in_if.wlast = 0; mem_if.wready = 0; settle();
    chk("x6_mem_wvalid", mem_if.wvalid, 1);
    rst = 0; settle();
    chk("x6_mem_wvalid_rst", mem_if.wvalid, 0);
    chk("x6_in_wready_rst", in_if.wready, 0);
    chk("x6_awready_rst", in_if.awready, 1);
    chk("x6_valids_rst", {mem_if.awvalid, mem_if.arvalid, clint_if.awvalid,
                          clint_if.wvalid, in_if.bvalid, in_if.rvalid}, 0);
    in_if.wvalid = 0;
    step(); rst = 1;
    step();
    in_if.arvalid = 1; in_if.araddr = 32'h0200_0008; in_if.arid = 4'd1; in_if.arlen = 0;
    step(); in_if.arvalid = 0; settle();
    chk("x6_clint_arvalid", clint_if.arvalid, 1);
    chk("x6_clint_araddr", clint_if.araddr, 64'h0200_0008);
    clint_if.arready = 1;
    step(); clint_if.arready = 0;
    clint_if.rvalid = 1; clint_if.rid = 4'd1; clint_if.rdata = 64'hCAFE; clint_if.rlast = 1;
    in_if.rready = 1; settle();
    chk("x6_rdata", in_if.rdata, 64'hCAFE);
    chk("x6_rlast", in_if.rlast, 1);
    step(); clint_if.rvalid = 0; clint_if.rlast = 0; in_if.rready = 0; settle();
    chk("x6_idle", in_if.awready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
